pipe_datapath: RTL

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/datapath_pkg.sv | 22 ++
 rtl/pipe_datapath_if.sv | 37 +++
 rtl/pipe_alu.sv | 31 +++
 rtl/pipe_datapath.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared opcode constants and MUL sequencer state type for pipe_datapath.
package datapath_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
  localparam logic [OP_W-1:0] OP_MOV = 4'b1011;
  localparam logic [OP_W-1:0] OP_MUL = 4'b1100;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/pipe_datapath_if.sv
// Instruction issue, writeback and debug-read bundle for pipe_datapath.
// master: instruction source / observer; slave: the datapath.
interface pipe_datapath_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) ();

  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    rs_addr;
  logic [AW-1:0]    rt_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] imm_data;
  logic             imm_sel;
  logic [3:0]       alu_sel;
  logic             rf_write;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             zero_flag;
  logic             pos_flag;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, rs_addr, rt_addr, rd_addr, imm_data, imm_sel, alu_sel,
           rf_write, dbg_addr,
    input  in_ready, wb_valid, wb_addr, wb_data, zero_flag, pos_flag, dbg_data
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, rd_addr, imm_data, imm_sel, alu_sel,
           rf_write, dbg_addr,
    output in_ready, wb_valid, wb_addr, wb_data, zero_flag, pos_flag, dbg_data
  );

endinterface

// File: rtl/pipe_alu.sv
// Combinational single-cycle ALU for pipe_datapath.
// Ports: op (opcode), a/b (operands), result_c (combinational result).
module pipe_alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c
);

  // Unlisted codes (including MUL, handled elsewhere) produce zero.
  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_NOT:  result_c = ~a;
      OP_SHL:  result_c = a << b[3:0];
      OP_SHR:  result_c = a >> b[3:0];
      OP_MOV:  result_c = b;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage datapath: register file + operand fetch/forwarding, EX stage with
// pipe_alu, optional shift-add multiplier (macro PIPE_DATAPATH_MUL_EN).
// Ports: clock, reset_n (async active-low), bus (pipe_datapath_if.slave):
//   issue in_valid/in_ready/rs/rt/rd/imm/imm_sel/alu_sel/rf_write,
//   writeback wb_valid/wb_addr/wb_data/zero_flag/pos_flag,
//   debug dbg_addr -> dbg_data (combinational register read).
module pipe_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  pipe_datapath_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             ex_valid;
  logic [OP_W-1:0]  ex_op;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [AW-1:0]    ex_rd;
  logic             ex_wr;
  logic [WIDTH-1:0] alu_result_c;

  pipe_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (ex_op),
    .a        (ex_a),
    .b        (ex_b),
    .result_c (alu_result_c)
  );

  logic             accept;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             is_mul_in;
  logic             retire;
  logic [WIDTH-1:0] retire_data;

  // Operand fetch; the in-flight EX result bypasses the register file.
  assign accept = bus.in_valid && bus.in_ready;
  assign fwd_a  = ex_valid && ex_wr && (ex_rd == bus.rs_addr);
  assign fwd_b  = ex_valid && ex_wr && (ex_rd == bus.rt_addr);
  assign opa    = fwd_a ? alu_result_c : regs[bus.rs_addr];
  assign opb    = bus.imm_sel ? bus.imm_data
                : (fwd_b ? alu_result_c : regs[bus.rt_addr]);
  assign bus.dbg_data = regs[bus.dbg_addr];

`ifdef PIPE_DATAPATH_MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_e       state_q;
  mul_state_e       state_d;
  logic             mul_start;
  logic             mul_done;
  logic [CW-1:0]    mul_cnt;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [WIDTH-1:0] mul_acc_next;

  assign is_mul_in    = (bus.alu_sel == OP_MUL);
  assign bus.in_ready = (state_q == MUL_IDLE);
  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  // MUL sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= MUL_IDLE;
    else          state_q <= state_d;
  end

  // MUL sequencer next state; in IDLE in_ready is 1, so in_valid alone accepts.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (bus.in_valid && is_mul_in) begin
          state_d   = MUL_BUSY;
          mul_start = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (mul_cnt == CW'(WIDTH - 1)) begin
          mul_done = 1'b1;
          state_d  = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Shift-add: one multiplier bit per busy cycle, product low WIDTH bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (mul_start) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= opa;
      mul_mplier <= opb;
    end else if (state_q == MUL_BUSY) begin
      mul_cnt    <= mul_cnt + CW'(1);
      mul_acc    <= mul_acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

  assign retire      = ex_valid || mul_done;
  assign retire_data = mul_done ? mul_acc_next : alu_result_c;
`else
  assign is_mul_in    = 1'b0;
  assign bus.in_ready = 1'b1;
  assign retire       = ex_valid;
  assign retire_data  = alu_result_c;
`endif

  // EX stage capture, retirement, register file write and flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      ex_valid      <= 1'b0;
      ex_op         <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_rd         <= '0;
      ex_wr         <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_addr   <= '0;
      bus.wb_data   <= '0;
      bus.zero_flag <= 1'b0;
      bus.pos_flag  <= 1'b0;
    end else begin
      // A MUL keeps rd/rf_write here but never occupies EX as a valid op.
      ex_valid <= accept && !is_mul_in;
      if (accept) begin
        ex_op <= bus.alu_sel;
        ex_a  <= opa;
        ex_b  <= opb;
        ex_rd <= bus.rd_addr;
        ex_wr <= bus.rf_write;
      end
      bus.wb_valid <= retire;
      if (retire) begin
        bus.wb_addr   <= ex_rd;
        bus.wb_data   <= retire_data;
        bus.zero_flag <= (retire_data == '0);
        bus.pos_flag  <= (retire_data != '0) && !retire_data[WIDTH-1];
        if (ex_wr) regs[ex_rd] <= retire_data;
      end
    end
  end

endmodule
